// File: rtl/preg_ready_table.sv
// Physical-register ready table: rename lanes mark destination pregs busy, writeback ports
// mark them ready. Optional same-cycle wakeup bypass is enabled by `define PRT_WAKE_BYPASS_EN.
module preg_ready_table #(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned PREG_NUM    = 64,
  parameter int unsigned WB_PORTS    = 4,
  localparam int unsigned PidW       = $clog2(PREG_NUM),
  localparam int unsigned CntW       = $clog2(PREG_NUM + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                stall,
  input  logic                                flush,
  input  logic [FETCH_WIDTH-1:0]              alloc_valid,
  input  logic [FETCH_WIDTH-1:0][PidW-1:0]    alloc_pid,
  input  logic [FETCH_WIDTH-1:0]              src1_valid,
  input  logic [FETCH_WIDTH-1:0][PidW-1:0]    src1_pid,
  input  logic [FETCH_WIDTH-1:0]              src2_valid,
  input  logic [FETCH_WIDTH-1:0][PidW-1:0]    src2_pid,
  input  logic [WB_PORTS-1:0]                 wb_valid,
  input  logic [WB_PORTS-1:0][PidW-1:0]       wb_pid,
  output logic [FETCH_WIDTH-1:0]              v1,
  output logic [FETCH_WIDTH-1:0]              v2,
  output logic [CntW-1:0]                     busy_cnt
);

  logic [PREG_NUM-1:0]    busy_q, busy_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [PREG_NUM-1:0]    wake;
  logic [PREG_NUM-1:0]    ready_tab;
  logic [FETCH_WIDTH-1:0] raw1, raw2;

  // Same-cycle wakeup vector; left at zero when the bypass is compiled out so that issue
  // readiness depends on registered state only.
  always_comb begin
    wake = '0;
`ifdef PRT_WAKE_BYPASS_EN
    for (int unsigned k = 0; k < WB_PORTS; k++) begin
      if (wb_valid[k]) wake[wb_pid[k]] = 1'b1;
    end
`endif
  end

  assign ready_tab = ~busy_q | wake;

  // Intra-group RAW: an older lane allocating the same preg makes the source not ready.
  always_comb begin
    raw1 = '0;
    raw2 = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      for (int unsigned j = 0; j < i; j++) begin
        if (alloc_valid[j] && (alloc_pid[j] == src1_pid[i])) raw1[i] = 1'b1;
        if (alloc_valid[j] && (alloc_pid[j] == src2_pid[i])) raw2[i] = 1'b1;
      end
    end
  end

  always_comb begin
    v1 = '0;
    v2 = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      v1[i] = ~src1_valid[i] | (src1_pid[i] == '0) | (ready_tab[src1_pid[i]] & ~raw1[i]);
      v2[i] = ~src2_valid[i] | (src2_pid[i] == '0) | (ready_tab[src2_pid[i]] & ~raw2[i]);
    end
  end

  // Wakeups first, then allocations, so allocation wins on a same-preg collision.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int unsigned k = 0; k < WB_PORTS; k++) begin
        if (wb_valid[k]) busy_d[wb_pid[k]] = 1'b0;
      end
      if (!stall) begin
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
          if (alloc_valid[i]) busy_d[alloc_pid[i]] = 1'b1;
        end
      end
      busy_d[0] = 1'b0;
    end
  end

  // Count is rebuilt from the next-state vector so duplicate pids cannot skew it.
  always_comb begin
    cnt_d = '0;
    for (int unsigned p = 0; p < PREG_NUM; p++) begin
      cnt_d = cnt_d + CntW'(busy_d[p]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_preg_ready_table.sv
// Self-checking bench for preg_ready_table: directed scenarios plus randomized traffic
// checked against a set-based busy model.
module tb_preg_ready_table;

  localparam int FW = 4;
  localparam int PN = 64;
  localparam int WB = 4;
  localparam int PW = 6;
  localparam int CW = 7;
`ifdef PRT_WAKE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 stall, flush;
  logic [FW-1:0]        alloc_valid, src1_valid, src2_valid;
  logic [WB-1:0]        wb_valid;
  logic [FW-1:0][PW-1:0] alloc_pid, src1_pid, src2_pid;
  logic [WB-1:0][PW-1:0] wb_pid;
  logic [FW-1:0]        v1, v2;
  logic [CW-1:0]        busy_cnt;

  int vectors = 0;
  int errors  = 0;
  bit mbusy[PN];

  preg_ready_table dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .alloc_valid(alloc_valid),
    .alloc_pid  (alloc_pid),
    .src1_valid (src1_valid),
    .src1_pid   (src1_pid),
    .src2_valid (src2_valid),
    .src2_pid   (src2_pid),
    .wb_valid   (wb_valid),
    .wb_pid     (wb_pid),
    .v1         (v1),
    .v2         (v2),
    .busy_cnt   (busy_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  // A source is ready unless it names a busy (and not bypass-woken) preg or a preg that an
  // older lane of the same group is allocating.
  function automatic logic ref_ready(int lane, logic sv, logic [PW-1:0] p);
    if (!sv || p == 0) return 1'b1;
    for (int j = 0; j < lane; j++)
      if (alloc_valid[j] && alloc_pid[j] == p) return 1'b0;
    if (Bypass)
      for (int k = 0; k < WB; k++)
        if (wb_valid[k] && wb_pid[k] == p) return 1'b1;
    return !mbusy[p];
  endfunction

  function automatic logic [FW-1:0] exp_v1();
    logic [FW-1:0] r;
    for (int i = 0; i < FW; i++) r[i] = ref_ready(i, src1_valid[i], src1_pid[i]);
    return r;
  endfunction

  function automatic logic [FW-1:0] exp_v2();
    logic [FW-1:0] r;
    for (int i = 0; i < FW; i++) r[i] = ref_ready(i, src2_valid[i], src2_pid[i]);
    return r;
  endfunction

  function automatic int model_cnt();
    int n = 0;
    for (int p = 0; p < PN; p++) n += int'(mbusy[p]);
    return n;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < PN; p++) mbusy[p] = 1'b0;
  endtask

  task automatic model_clock();
    if (flush) begin
      model_clear();
    end else begin
      for (int k = 0; k < WB; k++) if (wb_valid[k]) mbusy[wb_pid[k]] = 1'b0;
      if (!stall)
        for (int i = 0; i < FW; i++) if (alloc_valid[i]) mbusy[alloc_pid[i]] = 1'b1;
      mbusy[0] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0;
    alloc_valid = '0; src1_valid = '0; src2_valid = '0; wb_valid = '0;
    alloc_pid = '0; src1_pid = '0; src2_pid = '0; wb_pid = '0;
  endtask

  task automatic rand_srcs();
    src1_valid = 4'($urandom); src2_valid = 4'($urandom);
    for (int i = 0; i < FW; i++) begin
      src1_pid[i] = 6'($urandom); src2_pid[i] = 6'($urandom);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    model_clear();
    rand_srcs();
    #2;
    vectors++;
    if (v1 !== 4'b1111) begin errors++; $display("FAIL reset_v1: got %b want 1111", v1); end
    vectors++;
    if (v2 !== 4'b1111) begin errors++; $display("FAIL reset_v2: got %b want 1111", v2); end
    vectors++;
    if (busy_cnt !== 7'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", busy_cnt); end
    idle();
    src1_valid[0] = 1; src1_pid[0] = 5;
    #1;
    vectors++;
    if (v1[0] !== 1'b1) begin errors++; $display("FAIL reset_pid5: got %b want 1", v1[0]); end
    #1 reset = 1'b1;
    tick();
  endtask

  task automatic test_wakeup();
    idle();
    alloc_valid[0] = 1; alloc_pid[0] = 7;
    tick();
    vectors++;
    if (busy_cnt !== 7'd1) begin errors++; $display("FAIL alloc7_cnt: got %0d want 1", busy_cnt); end
    idle();
    src1_valid[1] = 1; src1_pid[1] = 7;
    #1;
    vectors++;
    if (v1[1] !== 1'b0) begin errors++; $display("FAIL busy7_v1: got %b want 0", v1[1]); end
    wb_valid[0] = 1; wb_pid[0] = 7;
    #1;
    vectors++;
    if (v1[1] !== Bypass) begin
      errors++; $display("FAIL wake7_same_cycle: got %b want %b", v1[1], Bypass);
    end
    tick();
    vectors++;
    if (busy_cnt !== 7'd0) begin errors++; $display("FAIL wake7_cnt: got %0d want 0", busy_cnt); end
    wb_valid = '0;
    #1;
    vectors++;
    if (v1[1] !== 1'b1) begin errors++; $display("FAIL wake7_next: got %b want 1", v1[1]); end
  endtask

  task automatic test_group_raw();
    idle();
    alloc_valid[0] = 1; alloc_pid[0] = 9;
    src2_valid[2] = 1; src2_pid[2] = 9;
    src2_valid[0] = 1; src2_pid[0] = 9;
    #1;
    vectors++;
    if (v2[2] !== 1'b0) begin errors++; $display("FAIL raw_lane2: got %b want 0", v2[2]); end
    vectors++;
    if (v2[0] !== 1'b1) begin errors++; $display("FAIL raw_own_lane: got %b want 1", v2[0]); end
    alloc_valid = 4'b1000; alloc_pid[3] = 9;
    #1;
    vectors++;
    if (v2[2] !== 1'b1) begin errors++; $display("FAIL raw_younger: got %b want 1", v2[2]); end
    idle();
    tick();
  endtask

  task automatic test_collision();
    int c0;
    idle();
    c0 = model_cnt();
    alloc_valid[1] = 1; alloc_pid[1] = 12;
    wb_valid[2] = 1; wb_pid[2] = 12;
    tick();
    vectors++;
    if (busy_cnt !== 7'(c0 + 1)) begin
      errors++; $display("FAIL collide_cnt: got %0d want %0d", busy_cnt, c0 + 1);
    end
    idle();
    src1_valid[0] = 1; src1_pid[0] = 12;
    #1;
    vectors++;
    if (v1[0] !== 1'b0) begin errors++; $display("FAIL collide_busy: got %b want 0", v1[0]); end
    idle();
    alloc_valid[0] = 1; alloc_pid[0] = 0;
    src1_valid[1] = 1; src1_pid[1] = 0;
    #1;
    vectors++;
    if (v1[1] !== 1'b1) begin errors++; $display("FAIL pid0_ready: got %b want 1", v1[1]); end
    tick();
    vectors++;
    if (busy_cnt !== 7'(c0 + 1)) begin
      errors++; $display("FAIL pid0_cnt: got %0d want %0d", busy_cnt, c0 + 1);
    end
  endtask

  task automatic test_stall();
    idle();
    alloc_valid[0] = 1; alloc_pid[0] = 21;
    tick();
    idle();
    stall = 1;
    alloc_valid[0] = 1; alloc_pid[0] = 20;
    wb_valid[1] = 1; wb_pid[1] = 21;
    src1_valid[2] = 1; src1_pid[2] = 21;
    #1;
    vectors++;
    if (v1 !== exp_v1()) begin errors++; $display("FAIL stall_v1: got %b want %b", v1, exp_v1()); end
    tick();
    idle();
    src1_valid[0] = 1; src1_pid[0] = 20;
    src2_valid[0] = 1; src2_pid[0] = 21;
    #1;
    vectors++;
    if (v1[0] !== 1'b1) begin errors++; $display("FAIL stall_alloc20: got %b want 1", v1[0]); end
    vectors++;
    if (v2[0] !== 1'b1) begin errors++; $display("FAIL stall_wake21: got %b want 1", v2[0]); end
    vectors++;
    if (busy_cnt !== 7'(model_cnt())) begin
      errors++; $display("FAIL stall_cnt: got %0d want %0d", busy_cnt, model_cnt());
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 8; c++) begin
      idle();
      for (int i = 0; i < FW; i++) begin
        alloc_valid[i] = (1 + 4 * c + i) <= 30;
        alloc_pid[i] = 6'(1 + 4 * c + i);
      end
      tick();
    end
    vectors++;
    if (busy_cnt !== 7'd30) begin errors++; $display("FAIL fill30_cnt: got %0d want 30", busy_cnt); end
    idle();
    flush = 1;
    alloc_valid = 4'b1111;
    for (int i = 0; i < FW; i++) alloc_pid[i] = 6'(40 + i);
    wb_valid[0] = 1; wb_pid[0] = 3;
    tick();
    vectors++;
    if (busy_cnt !== 7'd0) begin errors++; $display("FAIL flush_cnt: got %0d want 0", busy_cnt); end
    idle();
    src1_valid = 4'b1111; src2_valid = 4'b1111;
    for (int i = 0; i < FW; i++) begin
      src1_pid[i] = 6'(1 + i); src2_pid[i] = 6'(40 + i);
    end
    #1;
    vectors++;
    if (v1 !== 4'b1111) begin errors++; $display("FAIL flush_v1: got %b want 1111", v1); end
    vectors++;
    if (v2 !== 4'b1111) begin errors++; $display("FAIL flush_v2: got %b want 1111", v2); end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 5; c++) begin
      idle();
      alloc_valid = 4'($urandom);
      for (int i = 0; i < FW; i++) alloc_pid[i] = 6'($urandom_range(1, 63));
      tick();
    end
    idle();
    rand_srcs();
    #2 reset = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (busy_cnt !== 7'd0) begin errors++; $display("FAIL arst_cnt: got %0d want 0", busy_cnt); end
    vectors++;
    if (v1 !== 4'b1111) begin errors++; $display("FAIL arst_v1: got %b want 1111", v1); end
    vectors++;
    if (v2 !== 4'b1111) begin errors++; $display("FAIL arst_v2: got %b want 1111", v2); end
    #1 reset = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 19) == 0);
      alloc_valid = 4'($urandom); src1_valid = 4'($urandom);
      src2_valid = 4'($urandom); wb_valid = 4'($urandom);
      for (int i = 0; i < FW; i++) begin
        alloc_pid[i] = 6'($urandom_range(0, 15));
        src1_pid[i]  = 6'($urandom_range(0, 15));
        src2_pid[i]  = 6'($urandom_range(0, 15));
      end
      for (int k = 0; k < WB; k++) wb_pid[k] = 6'($urandom_range(0, 15));
      #1;
      vectors++;
      if (v1 !== exp_v1()) begin
        errors++; $display("FAIL rand_v1 cycle %0d: got %b want %b", c, v1, exp_v1());
      end
      vectors++;
      if (v2 !== exp_v2()) begin
        errors++; $display("FAIL rand_v2 cycle %0d: got %b want %b", c, v2, exp_v2());
      end
      tick();
      vectors++;
      if (busy_cnt !== 7'(model_cnt())) begin
        errors++; $display("FAIL rand_cnt cycle %0d: got %0d want %0d", c, busy_cnt, model_cnt());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_wakeup();
    test_group_raw();
    test_collision();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
